// File: rtl/falling_piece_sequencer_if.sv
// rtl/falling_piece_sequencer_if.sv - candidate-pose legality check handshake
interface falling_piece_sequencer_if;
    logic       check_req;
    logic [4:0] cand_row;
    logic [4:0] cand_col;
    logic [1:0] cand_orient;
    logic [3:0] cand_type;
    logic       check_ack;
    logic       check_ok;

    modport master (
        output check_req, cand_row, cand_col, cand_orient, cand_type,
        input  check_ack, check_ok
    );

    modport slave (
        input  check_req, cand_row, cand_col, cand_orient, cand_type,
        output check_ack, check_ok
    );
endinterface

// File: rtl/falling_piece_sequencer.sv
// rtl/falling_piece_sequencer.sv - active tetromino pose sequencer with shared legality checker
module falling_piece_sequencer #(
    parameter int unsigned GRAVITY_TICKS = 25_000_000,
    parameter logic [4:0]  SPAWN_ROW     = 5'd0,
    parameter logic [4:0]  SPAWN_COL     = 5'd3
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               spawn,
    input  logic [3:0]                         spawn_type,
    input  logic                               move_left,
    input  logic                               move_right,
    input  logic                               rotate_cw,
    input  logic                               soft_drop,
    falling_piece_sequencer_if.master          chk,
    output logic [4:0]                         origin_row,
    output logic [4:0]                         origin_col,
    output logic [1:0]                         orientation,
    output logic [3:0]                         falling_type,
    output logic                               active,
    output logic                               locked,
    output logic                               top_out
);
    localparam int              CW      = $clog2(GRAVITY_TICKS);
    localparam logic [CW-1:0]   CNT_MAX = CW'(GRAVITY_TICKS - 1);
    localparam logic [1:0]      K_ROT   = 2'd0;
    localparam logic [1:0]      K_LEFT  = 2'd1;
    localparam logic [1:0]      K_RIGHT = 2'd2;
    localparam logic [1:0]      K_DROP  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_SPAWN_CHK, S_FALLING, S_CHECK, S_LOCK
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    pend, pend_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    svc, svc_nx;
    logic          req, req_nx;
    logic [4:0]    c_row, c_row_nx, c_col, c_col_nx;
    logic [1:0]    c_or, c_or_nx;
    logic [3:0]    c_type, c_type_nx;
    logic [4:0]    p_row, p_row_nx, p_col, p_col_nx;
    logic [1:0]    p_or, p_or_nx;
    logic [3:0]    p_type, p_type_nx;
    logic          act, act_nx, top, top_nx;
    logic [3:0]    pulses;
    logic          wrap, to_lock;
    logic [1:0]    pick;

    assign pulses = {soft_drop, move_right, move_left, rotate_cw};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            pend   <= '0;
            cnt    <= '0;
            svc    <= K_ROT;
            req    <= 1'b0;
            c_row  <= SPAWN_ROW;
            c_col  <= SPAWN_COL;
            c_or   <= 2'd0;
            c_type <= 4'd0;
            p_row  <= SPAWN_ROW;
            p_col  <= SPAWN_COL;
            p_or   <= 2'd0;
            p_type <= 4'd0;
            act    <= 1'b0;
            top    <= 1'b0;
        end else begin
            state  <= state_nx;
            pend   <= pend_nx;
            cnt    <= cnt_nx;
            svc    <= svc_nx;
            req    <= req_nx;
            c_row  <= c_row_nx;
            c_col  <= c_col_nx;
            c_or   <= c_or_nx;
            c_type <= c_type_nx;
            p_row  <= p_row_nx;
            p_col  <= p_col_nx;
            p_or   <= p_or_nx;
            p_type <= p_type_nx;
            act    <= act_nx;
            top    <= top_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pend_nx   = pend;
        cnt_nx    = cnt;
        svc_nx    = svc;
        req_nx    = req;
        c_row_nx  = c_row;
        c_col_nx  = c_col;
        c_or_nx   = c_or;
        c_type_nx = c_type;
        p_row_nx  = p_row;
        p_col_nx  = p_col;
        p_or_nx   = p_or;
        p_type_nx = p_type;
        act_nx    = act;
        top_nx    = top;
        wrap      = 1'b0;
        to_lock   = 1'b0;
        pick      = K_DROP;
        if (pend[0])      pick = K_ROT;
        else if (pend[1]) pick = K_LEFT;
        else if (pend[2]) pick = K_RIGHT;

        unique case (state)
            S_IDLE: begin
                if (spawn && !top) begin
                    c_row_nx  = SPAWN_ROW;
                    c_col_nx  = SPAWN_COL;
                    c_or_nx   = 2'd0;
                    c_type_nx = spawn_type;
                    req_nx    = 1'b1;
                    state_nx  = S_SPAWN_CHK;
                end
            end
            S_SPAWN_CHK: begin
                if (chk.check_ack) begin
                    req_nx = 1'b0;
                    if (chk.check_ok) begin
                        p_row_nx  = c_row;
                        p_col_nx  = c_col;
                        p_or_nx   = c_or;
                        p_type_nx = c_type;
                        act_nx    = 1'b1;
                        state_nx  = S_FALLING;
                    end else begin
                        top_nx   = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
            end
            S_FALLING, S_CHECK: begin
                wrap   = (cnt == CNT_MAX);
                cnt_nx = (wrap || soft_drop) ? '0 : cnt + 1'b1;
                if (state == S_FALLING) begin
                    if (|pend) begin
                        // Candidate is the committed pose with exactly one field stepped.
                        c_row_nx  = (pick == K_DROP)  ? p_row + 5'd1 : p_row;
                        c_col_nx  = (pick == K_LEFT)  ? p_col - 5'd1 :
                                    (pick == K_RIGHT) ? p_col + 5'd1 : p_col;
                        c_or_nx   = (pick == K_ROT)   ? p_or + 2'd1  : p_or;
                        c_type_nx = p_type;
                        svc_nx    = pick;
                        req_nx    = 1'b1;
                        state_nx  = S_CHECK;
                    end
                end else if (chk.check_ack) begin
                    req_nx       = 1'b0;
                    pend_nx[svc] = 1'b0;
                    if (chk.check_ok) begin
                        p_row_nx = c_row;
                        p_col_nx = c_col;
                        p_or_nx  = c_or;
                        state_nx = S_FALLING;
                    end else if (svc == K_DROP) begin
                        to_lock = 1'b1;
                    end else begin
                        state_nx = S_FALLING;
                    end
                end
                // A fresh pulse in the ack cycle re-arms its bit after servicing clears it.
                pend_nx = pend_nx | pulses | {wrap, 3'b000};
                if (to_lock) begin
                    state_nx = S_LOCK;
                    pend_nx  = '0;
                    cnt_nx   = '0;
                    act_nx   = 1'b0;
                end
            end
            S_LOCK: begin
                pend_nx  = '0;
                cnt_nx   = '0;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign chk.check_req   = req;
    assign chk.cand_row    = c_row;
    assign chk.cand_col    = c_col;
    assign chk.cand_orient = c_or;
    assign chk.cand_type   = c_type;
    assign origin_row      = p_row;
    assign origin_col      = p_col;
    assign orientation     = p_or;
    assign falling_type    = p_type;
    assign active          = act;
    assign top_out         = top;
    assign locked          = (state == S_LOCK);
endmodule

// File: tb/tb_falling_piece_sequencer.sv
// tb/tb_falling_piece_sequencer.sv - directed and randomized bench with behavioural pose model
module tb_falling_piece_sequencer;
    localparam int GT = 8;
    localparam int SR = 0;
    localparam int SC = 3;
    localparam int M_IDLE = 0, M_SPAWN = 1, M_FALL = 2, M_CHECK = 3, M_LOCK = 4;

    logic       clk = 1'b0;
    logic       reset_n, spawn, move_left, move_right, rotate_cw, soft_drop;
    logic [3:0] spawn_type;
    logic [4:0] origin_row, origin_col;
    logic [1:0] orientation;
    logic [3:0] falling_type;
    logic       active, locked, top_out;

    falling_piece_sequencer_if ck();

    falling_piece_sequencer #(.GRAVITY_TICKS(GT), .SPAWN_ROW(5'(SR)), .SPAWN_COL(5'(SC))) dut (
        .clk(clk), .reset_n(reset_n), .spawn(spawn), .spawn_type(spawn_type),
        .move_left(move_left), .move_right(move_right), .rotate_cw(rotate_cw),
        .soft_drop(soft_drop), .chk(ck), .origin_row(origin_row), .origin_col(origin_col),
        .orientation(orientation), .falling_type(falling_type), .active(active),
        .locked(locked), .top_out(top_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: pose, candidate, and the set of outstanding requests.
    int m_mode, m_timer, m_svc;
    bit m_pend[4];
    bit m_req, m_active, m_top;
    int m_crow, m_ccol, m_cor, m_ctype;
    int m_row, m_col, m_or, m_type;

    int wait_left = 0, wait_max = 0, rej_pct = 0;
    bit block_spawn = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_timer = 0; m_svc = 0;
        for (int i = 0; i < 4; i++) m_pend[i] = 0;
        m_req = 0; m_active = 0; m_top = 0;
        m_crow = SR; m_ccol = SC; m_cor = 0; m_ctype = 0;
        m_row = SR; m_col = SC; m_or = 0; m_type = 0;
    endtask

    function automatic bit any_pend();
        return m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3];
    endfunction

    task automatic model_step();
        bit pulses[4];
        bit wrap, to_lock;
        int k;
        pulses[0] = rotate_cw; pulses[1] = move_left; pulses[2] = move_right; pulses[3] = soft_drop;
        if (!reset_n) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_IDLE: if (spawn && !m_top) begin
                m_crow = SR; m_ccol = SC; m_cor = 0; m_ctype = spawn_type;
                m_req = 1; m_mode = M_SPAWN;
            end
            M_SPAWN: if (ck.check_ack) begin
                m_req = 0;
                if (ck.check_ok) begin
                    m_row = m_crow; m_col = m_ccol; m_or = m_cor; m_type = m_ctype;
                    m_active = 1; m_mode = M_FALL;
                end else begin
                    m_top = 1; m_mode = M_IDLE;
                end
            end
            M_FALL, M_CHECK: begin
                wrap = (m_timer == GT - 1);
                to_lock = 0;
                m_timer = (wrap || soft_drop) ? 0 : m_timer + 1;
                if (m_mode == M_FALL) begin
                    k = -1;
                    for (int i = 3; i >= 0; i--) if (m_pend[i]) k = i;
                    if (k >= 0) begin
                        m_svc = k;
                        m_crow = (k == 3) ? (m_row + 1) % 32 : m_row;
                        m_ccol = (k == 1) ? (m_col + 31) % 32 : (k == 2) ? (m_col + 1) % 32 : m_col;
                        m_cor = (k == 0) ? (m_or + 1) % 4 : m_or;
                        m_ctype = m_type;
                        m_req = 1; m_mode = M_CHECK;
                    end
                end else if (ck.check_ack) begin
                    m_req = 0;
                    m_pend[m_svc] = 0;
                    if (ck.check_ok) begin
                        m_row = m_crow; m_col = m_ccol; m_or = m_cor;
                        m_mode = M_FALL;
                    end else if (m_svc == 3) to_lock = 1;
                    else m_mode = M_FALL;
                end
                for (int i = 0; i < 4; i++) m_pend[i] = m_pend[i] | pulses[i];
                if (wrap) m_pend[3] = 1;
                if (to_lock) begin
                    m_mode = M_LOCK; m_timer = 0; m_active = 0;
                    for (int i = 0; i < 4; i++) m_pend[i] = 0;
                end
            end
            default: begin
                m_mode = M_IDLE; m_timer = 0;
                for (int i = 0; i < 4; i++) m_pend[i] = 0;
            end
        endcase
    endtask

    task automatic compare();
        chk("check_req", ck.check_req, m_req);
        if (m_req) begin
            chk("cand_row", ck.cand_row, m_crow);
            chk("cand_col", ck.cand_col, m_ccol);
            chk("cand_orient", ck.cand_orient, m_cor);
            chk("cand_type", ck.cand_type, m_ctype);
        end
        chk("origin_row", origin_row, m_row);
        chk("origin_col", origin_col, m_col);
        chk("orientation", orientation, m_or);
        chk("falling_type", falling_type, m_type);
        chk("active", active, m_active);
        chk("locked", locked, m_mode == M_LOCK);
        chk("top_out", top_out, m_top);
    endtask

    // Pretend playfield: rows 0..18, cols 0..6 legal, plus optional random rejections.
    function automatic bit legal();
        if (block_spawn) return 0;
        if (ck.cand_row > 18 || ck.cand_col > 6) return 0;
        if (m_mode != M_SPAWN && $urandom_range(0, 99) < rej_pct) return 0;
        return 1;
    endfunction

    task automatic step();
        if (ck.check_req) begin
            if (wait_left == 0) begin
                ck.check_ack = 1; ck.check_ok = legal();
                wait_left = $urandom_range(0, wait_max);
            end else begin
                ck.check_ack = 0; wait_left--;
            end
        end else begin
            ck.check_ack = 0; ck.check_ok = 0;
        end
        @(posedge clk);
        model_step();
        #1;
        spawn = 0; move_left = 0; move_right = 0; rotate_cw = 0; soft_drop = 0;
        ck.check_ack = 0;
        @(negedge clk);
        compare();
    endtask

    task automatic settle();
        int n = 0;
        while ((m_mode == M_CHECK || any_pend()) && n < 60) begin step(); n++; end
        chk("settle_timeout", n < 60, 1);
    endtask

    task automatic spawn_piece(input logic [3:0] t);
        int n = 0;
        spawn_type = t; spawn = 1;
        step();
        while (!active && n < 20) begin step(); n++; end
        chk("spawn_timeout", n < 20, 1);
    endtask

    initial begin
        logic [4:0] r0, c0;
        logic [1:0] o0;
        int n;
        reset_n = 0; spawn = 0; spawn_type = 0; move_left = 0; move_right = 0;
        rotate_cw = 0; soft_drop = 0; ck.check_ack = 0; ck.check_ok = 0;
        model_reset();
        @(negedge clk);
        repeat (3) step();
        reset_n = 1;
        step();
        chk("rst_row", origin_row, SR);
        chk("rst_col", origin_col, SC);
        chk("rst_active", active, 0);

        // T1: legal spawn commits spawn pose
        spawn_piece(4'd6);
        chk("t1_row", origin_row, 0);
        chk("t1_col", origin_col, 3);
        chk("t1_orient", orientation, 0);
        chk("t1_type", falling_type, 6);

        // T2: left off column 0 wraps candidate to 31 and is rejected
        for (int i = 0; i < 3; i++) begin move_left = 1; step(); settle(); end
        chk("t2_col0", origin_col, 0);
        move_left = 1; step();
        n = 0;
        while (!(m_req && m_svc == 1) && n < 20) begin step(); n++; end
        chk("t2_cand_col", ck.cand_col, 31);
        settle();
        chk("t2_col_hold", origin_col, 0);
        chk("t2_active", active, 1);

        // T3: gravity alone advances the row
        r0 = origin_row;
        repeat (40) step();
        chk("t3_fell", origin_row > r0, 1);

        // T4: simultaneous rotate+left+drop serviced in priority order
        move_right = 1; step(); settle();
        r0 = origin_row; c0 = origin_col; o0 = orientation;
        rotate_cw = 1; move_left = 1; soft_drop = 1; step();
        repeat (6) step();
        chk("t4_orient", orientation, 2'(o0 + 2'd1));
        chk("t4_col", origin_col, 5'(c0 - 5'd1));
        chk("t4_row", origin_row, 5'(r0 + 5'd1));

        // T5: rejected drop at row 18 locks the piece
        n = 0;
        while (!locked && n < 400) begin step(); n++; end
        chk("t5_lock_seen", locked, 1);
        chk("t5_row", origin_row, 18);
        chk("t5_active", active, 0);
        step();
        chk("t5_lock_pulse", locked, 0);

        // Randomized play with random checker latency and rejections
        wait_max = 2; rej_pct = 20;
        for (int p = 0; p < 8; p++) begin
            spawn_type = 4'($urandom_range(1, 7)); spawn = 1; step();
            n = 0;
            while (m_mode != M_IDLE && n < 400) begin
                rotate_cw  = ($urandom_range(0, 5) == 0);
                move_left  = ($urandom_range(0, 5) == 0);
                move_right = ($urandom_range(0, 5) == 0);
                soft_drop  = ($urandom_range(0, 9) == 0);
                step(); n++;
            end
            chk("rand_piece_done", n < 400, 1);
        end
        wait_max = 0; rej_pct = 0;

        // T6: illegal spawn tops out; later spawns ignored; reset mid-check
        reset_n = 0; step(); step(); reset_n = 1; step();
        block_spawn = 1; spawn_type = 4'd2; spawn = 1; step();
        repeat (3) step();
        chk("t6_top_out", top_out, 1);
        chk("t6_inactive", active, 0);
        block_spawn = 0; spawn = 1; step();
        repeat (3) step();
        chk("t6_ignored_req", ck.check_req, 0);
        chk("t6_top_sticky", top_out, 1);
        reset_n = 0; step(); reset_n = 1; step();
        spawn_piece(4'd5);
        rotate_cw = 1; step();
        n = 0;
        while (!ck.check_req && n < 20) begin step(); n++; end
        chk("t6_req_seen", ck.check_req, 1);
        reset_n = 0; step(); reset_n = 1;
        chk("t6_rst_req", ck.check_req, 0);
        chk("t6_rst_row", origin_row, SR);
        chk("t6_rst_col", origin_col, SC);
        chk("t6_rst_orient", orientation, 0);
        chk("t6_rst_type", falling_type, 0);
        chk("t6_rst_active", active, 0);
        chk("t6_rst_top", top_out, 0);
        chk("t6_rst_locked", locked, 0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
